// File: rtl/rd16_sub_pipe_if.sv
// Operand/result handshake bundle for rd16_sub_pipe.
// Optional compare outputs (lt/ltu/eq) exist only when RD_SUB_CMP_EN is defined.
interface rd16_sub_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
`ifdef RD_SUB_CMP_EN
    logic        lt;
    logic        ltu;
    logic        eq;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, diff, borrow, ovf, lt, ltu, eq);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, diff, borrow, ovf, lt, ltu, eq);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, diff, borrow, ovf);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, diff, borrow, ovf);
`endif
endinterface

// File: rtl/rd16_sub_pipe.sv
// Pipelined 16-bit kill/propagate/generate prefix subtractor, one prefix level per stage.
// Define RD_SUB_CMP_EN to add registered lt/ltu/eq compare outputs.
module rd16_sub_pipe #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 6
) (
    input  logic           clk,
    input  logic           rst,
    rd16_sub_pipe_if.slave bus
);
    localparam int NPOS = WIDTH + 1;   // index 0 is the carry-in at position -1
    localparam int NLVL = 4;

    logic                w_adv;
    logic [LATENCY-1:0]  r_vld;
    logic [WIDTH-1:0]    r_a   [0:NLVL];
    logic [WIDTH-1:0]    r_nb  [0:NLVL];
    logic [NPOS-1:0]     r_g   [0:NLVL];
    logic [NPOS-1:0]     r_p   [0:NLVL];
    logic                r_sa  [0:NLVL];
    logic                r_sb  [0:NLVL];
    logic [NPOS-1:0]     w_g   [1:NLVL];
    logic [NPOS-1:0]     w_p   [1:NLVL];
    logic [WIDTH-1:0]    w_nb_in;
    logic [NPOS-1:0]     w_g0;
    logic [NPOS-1:0]     w_p0;
    logic [WIDTH:0]      w_c;
    logic [WIDTH-1:0]    w_diff;
    logic                w_ovf;
    logic [WIDTH-1:0]    r_diff;
    logic                r_borrow;
    logic                r_ovf;

    assign w_adv        = ~r_vld[LATENCY-1] | bus.out_ready;
    assign bus.in_ready = w_adv;

    assign w_nb_in = ~bus.b;
    assign w_g0    = {bus.a & w_nb_in, 1'b1};
    assign w_p0    = {bus.a ^ w_nb_in, 1'b0};

    // Codes are one-hot k/p/g, so "p over x gives x" reduces to g|p&g' and p&p'.
    generate
        for (genvar gi = 1; gi <= NLVL; gi++) begin : g_lvl
            localparam int D = 1 << (gi - 1);
            for (genvar gj = 0; gj < NPOS; gj++) begin : g_bit
                if (gj >= D) begin : g_comb
                    assign w_g[gi][gj] = r_g[gi-1][gj] | (r_p[gi-1][gj] & r_g[gi-1][gj-D]);
                    assign w_p[gi][gj] = r_p[gi-1][gj] & r_p[gi-1][gj-D];
                end else begin : g_pass
                    assign w_g[gi][gj] = r_g[gi-1][gj];
                    assign w_p[gi][gj] = r_p[gi-1][gj];
                end
            end
        end
    endgenerate

    // Four levels reach back 16 positions; the top position still needs the
    // always-generating carry-in folded in, so p there also yields a carry.
    assign w_c[WIDTH-1:0] = r_g[NLVL][WIDTH-1:0];
    assign w_c[WIDTH]     = r_g[NLVL][WIDTH] | r_p[NLVL][WIDTH];
    assign w_diff         = r_a[NLVL] ^ r_nb[NLVL] ^ w_c[WIDTH-1:0];
    assign w_ovf          = (r_sa[NLVL] ^ r_sb[NLVL]) & (w_diff[WIDTH-1] ^ r_sa[NLVL]);

`ifdef RD_SUB_CMP_EN
    logic r_lt, r_ltu, r_eq;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lt  <= 1'b0;
            r_ltu <= 1'b0;
            r_eq  <= 1'b0;
        end else if (w_adv) begin
            r_lt  <= w_diff[WIDTH-1] ^ w_ovf;
            r_ltu <= ~w_c[WIDTH];
            r_eq  <= (w_diff == '0);
        end
    end
    assign bus.lt  = r_lt;
    assign bus.ltu = r_ltu;
    assign bus.eq  = r_eq;
`endif

    // Whole pipeline moves as one; bubbles advance with their don't-care data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            for (int s = 0; s <= NLVL; s++) begin
                r_a[s]  <= '0;
                r_nb[s] <= '0;
                r_g[s]  <= '0;
                r_p[s]  <= '0;
                r_sa[s] <= 1'b0;
                r_sb[s] <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld   <= {r_vld[LATENCY-2:0], bus.in_valid};
            r_a[0]  <= bus.a;
            r_nb[0] <= w_nb_in;
            r_g[0]  <= w_g0;
            r_p[0]  <= w_p0;
            r_sa[0] <= bus.a[WIDTH-1];
            r_sb[0] <= bus.b[WIDTH-1];
            for (int s = 1; s <= NLVL; s++) begin
                r_a[s]  <= r_a[s-1];
                r_nb[s] <= r_nb[s-1];
                r_g[s]  <= w_g[s];
                r_p[s]  <= w_p[s];
                r_sa[s] <= r_sa[s-1];
                r_sb[s] <= r_sb[s-1];
            end
            r_diff   <= w_diff;
            r_borrow <= ~w_c[WIDTH];
            r_ovf    <= w_ovf;
        end
    end

    assign bus.out_valid = r_vld[LATENCY-1];
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_borrow;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_rd16_sub_pipe.sv
// Self-checking bench for rd16_sub_pipe: directed cases plus a randomized handshake phase.
// Compare outputs are also checked when RD_SUB_CMP_EN is defined.
module tb_rd16_sub_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rd16_sub_pipe_if bus ();
    rd16_sub_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        br;
        logic        ov;
        logic        lt;
        logic        ltu;
        logic        eq;
        int          t;
        bit          seen;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   lat_check;
    bit   acc;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int t);
        exp_t e;
        int   sa, sb, sd;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        sd    = sa - sb;
        e.a   = a;
        e.b   = b;
        e.d   = 16'((int'(a) - int'(b)) & 32'hFFFF);
        e.br  = (a < b);
        e.ov  = (sd > 32767) || (sd < -32768);
        e.lt  = (sa < sb);
        e.ltu = (a < b);
        e.eq  = (a == b);
        e.t   = t;
        e.seen = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check comb/registered outputs, then step.
    task automatic cycle(input bit iv, input logic [15:0] av, input logic [15:0] bv,
                         input bit ordy, output bit accepted);
        bus.in_valid  = iv;
        bus.a         = av;
        bus.b         = bv;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !(bus.out_valid && !ordy)});
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                chk("diff",   {16'd0, bus.diff},   {16'd0, q[0].d});
                chk("borrow", {31'd0, bus.borrow}, {31'd0, q[0].br});
                chk("ovf",    {31'd0, bus.ovf},    {31'd0, q[0].ov});
`ifdef RD_SUB_CMP_EN
                chk("lt",  {31'd0, bus.lt},  {31'd0, q[0].lt});
                chk("ltu", {31'd0, bus.ltu}, {31'd0, q[0].ltu});
                chk("eq",  {31'd0, bus.eq},  {31'd0, q[0].eq});
`endif
                if (lat_check && !q[0].seen)
                    chk("latency", cyc - q[0].t, 32'd6);
                q[0].seen = 1'b1;
                if (ordy) begin
                    $display("[TB] cyc %0d a=%h b=%h diff=%h borrow=%0b ovf=%0b",
                             cyc, q[0].a, q[0].b, bus.diff, bus.borrow, bus.ovf);
                    void'(q.pop_front());
                end
            end
        end
        accepted = iv && bus.in_ready;
        if (accepted) q.push_back(model(av, bv, cyc));
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);
        chk("drained", q.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] ua [0:2];
        logic [15:0] ub [0:2];
        logic [15:0] sa, sb;
        int          k, stall_left;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        lat_check     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_diff",      {16'd0, bus.diff},      32'd0);
        chk("rst_borrow",    {31'd0, bus.borrow},    32'd0);
        chk("rst_ovf",       {31'd0, bus.ovf},       32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);

        // Idle-after-reset single op, exact 6-cycle latency
        cycle(1'b1, 16'h1234, 16'h0234, 1'b1, acc);
        drain(12);

        // Underflow and both signed-overflow directions, back to back
        ua[0] = 16'h0000; ub[0] = 16'h0001;
        ua[1] = 16'h8000; ub[1] = 16'h0001;
        ua[2] = 16'h7FFF; ub[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) cycle(1'b1, ua[i], ub[i], 1'b1, acc);
        drain(12);

        // Streaming 8 ops
        for (int i = 0; i < 8; i++) begin
            sa = 16'((i * 32'h1111) & 32'hFFFF);
            cycle(1'b1, sa, 16'h0F0F, 1'b1, acc);
        end
        drain(12);

        // Backpressure: 10 ops, out_ready low for 4 cycles mid-stream
        lat_check = 1'b0;
        k = 0;
        stall_left = 4;
        for (int c = 0; c < 60 && k < 10; c++) begin
            sa = 16'((k * 32'h0123 + 32'h0400) & 32'hFFFF);
            sb = 16'((k * 32'h0321) & 32'hFFFF);
            if (c >= 7 && stall_left > 0) begin
                stall_left--;
                cycle(1'b1, sa, sb, 1'b0, acc);
            end else begin
                cycle(1'b1, sa, sb, 1'b1, acc);
            end
            if (acc) k++;
        end
        chk("bp_all_issued", k, 32'd10);
        drain(20);

        // Reset with 3 ops in flight and the head result stalled at the output
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h1000 + 16'(i), 16'h0001, 1'b0, acc);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, acc);
        #1;
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_diff",      {16'd0, bus.diff},      32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        lat_check = 1'b1;
        cycle(1'b1, 16'hAAAA, 16'hAAAA, 1'b1, acc);
        drain(12);

        // Randomized traffic with random backpressure
        lat_check = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) != 0), acc);
        end
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
